rename_map_table: RTL and testbench
===================================

Name: rename_map_table

Overview:
- Parametrised successor of the OOO-OTTER register map table for the Tomasulo back end.
- Tracks which reservation-station tag will produce each architectural register.
- Serves source tags to issue, with same-cycle CDB bypass.
- Accepts NUM_CDB result buses per cycle, generates register-file writes, and keeps NUM_CKPT branch checkpoints for misprediction recovery.

Parameters:
- NUM_REGS, 32, architectural registers; x0 never renamed.
- TAG_W, 4, RS tag width; tag value 0 is INVALID.
- NUM_CDB, 2, CDB channels and reg-file write ports.
- NUM_CKPT, 4, checkpoint slots.
- XLEN, 32, data width.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- issue_valid  in  1  instruction issues this cycle.
- rd_we  in  1  issued instruction writes rd.
- rd_addr  in  log2(NUM_REGS)  destination register.
- issue_tag  in  TAG_W  RS tag of the issued instruction; never 0.
- rs1_addr, rs2_addr  in  log2(NUM_REGS) each  source registers.
- rs1_used, rs2_used  in  1 each  source is read.
- t1, t2  out  TAG_W each  pending producer tag; 0 = value is ready.
- fwd1_valid, fwd2_valid  out  1 each  source is satisfied by the CDB this cycle.
- fwd1_data, fwd2_data  out  XLEN each  bypassed CDB value.
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- cdb_tag  in  NUM_CDB*TAG_W  broadcast tags.
- cdb_data  in  NUM_CDB*XLEN  broadcast values.
- wb_valid  out  NUM_CDB  reg-file write enables.
- wb_addr  out  NUM_CDB*log2(NUM_REGS)  reg-file write addresses.
- wb_data  out  NUM_CDB*XLEN  reg-file write data.
- ckpt_save  in  1  snapshot the map into slot ckpt_id.
- ckpt_restore  in  1  restore the map from slot ckpt_id.
- ckpt_id  in  log2(NUM_CKPT)  slot index.
- flush  in  1  clear all mappings.

Behaviour:

Map storage and reset
- Each entry is {busy, tag}.
- RST asynchronously clears every map entry and every checkpoint entry to {0,0}.
- While RST is high, wb_valid = 0, wb_addr = 0, wb_data = 0.

Source lookup (combinational)
- t1 is 0 if rs1_used = 0, rs1_addr = 0, or the entry is not busy. Otherwise t1 is the entry tag.
- Bypass: if any valid CDB channel's tag equals that entry tag, t1 = 0, fwd1_valid = 1, and fwd1_data is that channel's data.
- t2, fwd2_valid and fwd2_data follow the same rules using rs2.
- Lookup reflects the map before this cycle's issue update, so an instruction whose rd equals its rs sees the old mapping.
- Store and load operand selection is handled by the caller through rs*_used.

Issue (posedge)
- If issue_valid & rd_we & rd_addr != 0, then map[rd_addr] <= {1, issue_tag}.
- This always overwrites, including when the entry is already busy: renaming replaces the older producer.

CDB wakeup (posedge)
- For each channel c with cdb_valid[c], every map entry with busy = 1 and tag = cdb_tag[c] is cleared to {0,0}.
- For each such match, the block registers wb_valid[c] = 1, wb_addr[c] = the register index, and wb_data[c] = cdb_data[c].
- Write-back latency is 1 cycle.
- If a tag matches no entry (rd was renamed again, or was x0), wb_valid[c] = 0 and no write occurs.
- Tags are unique, so each channel matches at most one entry.

Simultaneous events, priority highest first
1. RST.
2. flush: clears all map busy bits; checkpoints are untouched; issue is ignored; the CDB still generates writes from the pre-flush map.
3. ckpt_restore: map <= slot ckpt_id, with this cycle's CDB matches also cleared in the restored value; issue is ignored.
4. Issue to rd_addr together with a CDB clear of the same entry: issue wins, and the entry ends {1, issue_tag}. The write-back for the old tag is still emitted.

Checkpoints
- ckpt_save copies the post-issue, post-CDB map of the same edge into slot ckpt_id.
- Every cycle, CDB matches also clear the busy bit in all checkpoint slots, so restored maps never reference completed tags.
- ckpt_save and ckpt_restore asserted together: restore wins and save is ignored.

Test Plan:
1. Reset, then issue rd=5, tag=3. Next cycle rs1=5, rs1_used=1 -> t1=3. Then CDB0 {tag 3, data 0xDEADBEEF} -> that cycle fwd1_valid=1, t1=0; next cycle wb_valid[0]=1, wb_addr[0]=5, wb_data[0]=0xDEADBEEF; entry 5 not busy.
2. Issue rd=7 tag=2, then rd=7 tag=4. Broadcast tag 2 -> wb_valid=0. Broadcast tag 4 -> writes x7.
3. Same cycle: issue rd=9 tag=6 while CDB1 completes tag 1 mapped to x9 -> wb to x9 with tag 1's data; entry 9 = {1,6}.
4. Two channels in the same cycle: tags 1 (x3) and 2 (x4) -> both wb ports valid next cycle, with correct addresses and data.
5. Map x2=tag5, ckpt_save id=1. Issue x2=tag7. CDB tag5. ckpt_restore id=1 -> x2 not busy; x2 lookup gives t1=0.
6. Issue rd=0 tag=3 -> no mapping. Mid-run RST asserted between edges -> all t*=0 and wb_valid=0 immediately.

Source files
------------

// File: rtl/rename_map_table.sv
// Register rename map for the Tomasulo back end: source tag lookup with CDB bypass,
// CDB-driven register-file write-back, flush, and branch checkpoint save/restore.
module rename_map_table #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned NUM_CDB  = 2,
    parameter int unsigned NUM_CKPT = 4,
    parameter int unsigned XLEN     = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 issue_valid_i,
    input  logic                                 rd_we_i,
    input  logic [$clog2(NUM_REGS)-1:0]          rd_addr_i,
    input  logic [TAG_W-1:0]                     issue_tag_i,
    input  logic [$clog2(NUM_REGS)-1:0]          rs1_addr_i,
    input  logic [$clog2(NUM_REGS)-1:0]          rs2_addr_i,
    input  logic                                 rs1_used_i,
    input  logic                                 rs2_used_i,
    output logic [TAG_W-1:0]                     t1_o,
    output logic [TAG_W-1:0]                     t2_o,
    output logic                                 fwd1_valid_o,
    output logic                                 fwd2_valid_o,
    output logic [XLEN-1:0]                      fwd1_data_o,
    output logic [XLEN-1:0]                      fwd2_data_o,
    input  logic [NUM_CDB-1:0]                   cdb_valid_i,
    input  logic [NUM_CDB*TAG_W-1:0]             cdb_tag_i,
    input  logic [NUM_CDB*XLEN-1:0]              cdb_data_i,
    output logic [NUM_CDB-1:0]                   wb_valid_o,
    output logic [NUM_CDB*$clog2(NUM_REGS)-1:0]  wb_addr_o,
    output logic [NUM_CDB*XLEN-1:0]              wb_data_o,
    input  logic                                 ckpt_save_i,
    input  logic                                 ckpt_restore_i,
    input  logic [$clog2(NUM_CKPT)-1:0]          ckpt_id_i,
    input  logic                                 flush_i
);

    localparam int unsigned REG_AW   = $clog2(NUM_REGS);
    localparam int unsigned NUM_TAGS = 1 << TAG_W;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef struct packed {
        logic [TAG_W-1:0] t;
        logic             fwd;
        logic [XLEN-1:0]  data;
    } lookup_t;

    entry_t                     map_q  [NUM_REGS];
    entry_t                     map_d  [NUM_REGS];
    entry_t                     map_clr[NUM_REGS];
    entry_t                     ckpt_q  [NUM_CKPT][NUM_REGS];
    entry_t                     ckpt_d  [NUM_CKPT][NUM_REGS];
    entry_t                     ckpt_clr[NUM_CKPT][NUM_REGS];
    logic [NUM_CDB-1:0]         wb_valid_q, wb_valid_d;
    logic [NUM_CDB*REG_AW-1:0]  wb_addr_q,  wb_addr_d;
    logic [NUM_CDB*XLEN-1:0]    wb_data_q,  wb_data_d;
    logic [NUM_TAGS-1:0]        tag_hit;
    lookup_t                    src1, src2;

    // Source lookup against the pre-issue map, overridden by a matching CDB broadcast.
    function automatic lookup_t lookup(input logic [REG_AW-1:0]        addr,
                                       input logic                     used,
                                       input entry_t                   e,
                                       input logic [NUM_CDB-1:0]       cv,
                                       input logic [NUM_CDB*TAG_W-1:0] ct,
                                       input logic [NUM_CDB*XLEN-1:0]  cd);
        lookup_t res;
        res = '0;
        if (used && (addr != '0) && e.busy) begin
            res.t = e.tag;
            for (int unsigned c = 0; c < NUM_CDB; c++) begin
                if (cv[c] && (ct[c*TAG_W +: TAG_W] == e.tag)) begin
                    res.t    = '0;
                    res.fwd  = 1'b1;
                    res.data = cd[c*XLEN +: XLEN];
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        src1 = lookup(rs1_addr_i, rs1_used_i, map_q[rs1_addr_i], cdb_valid_i, cdb_tag_i, cdb_data_i);
        src2 = lookup(rs2_addr_i, rs2_used_i, map_q[rs2_addr_i], cdb_valid_i, cdb_tag_i, cdb_data_i);
    end

    assign t1_o         = src1.t;
    assign t2_o         = src2.t;
    assign fwd1_valid_o = src1.fwd;
    assign fwd2_valid_o = src2.fwd;
    assign fwd1_data_o  = src1.data;
    assign fwd2_data_o  = src2.data;

    // One bit per tag value completing on any CDB channel this cycle.
    always_comb begin
        tag_hit = '0;
        for (int unsigned c = 0; c < NUM_CDB; c++) begin
            if (cdb_valid_i[c]) begin
                tag_hit[cdb_tag_i[c*TAG_W +: TAG_W]] = 1'b1;
            end
        end
    end

    // Next map, checkpoints and write-back; flush beats restore beats issue.
    always_comb begin
        wb_valid_d = '0;
        wb_addr_d  = '0;
        wb_data_d  = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            map_clr[r] = (map_q[r].busy && tag_hit[map_q[r].tag]) ? '0 : map_q[r];
            for (int unsigned k = 0; k < NUM_CKPT; k++) begin
                ckpt_clr[k][r] = (ckpt_q[k][r].busy && tag_hit[ckpt_q[k][r].tag]) ? '0 : ckpt_q[k][r];
            end
        end

        for (int unsigned c = 0; c < NUM_CDB; c++) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (cdb_valid_i[c] && map_q[r].busy && (map_q[r].tag == cdb_tag_i[c*TAG_W +: TAG_W])) begin
                    wb_valid_d[c]                  = 1'b1;
                    wb_addr_d[c*REG_AW +: REG_AW]  = REG_AW'(r);
                    wb_data_d[c*XLEN +: XLEN]      = cdb_data_i[c*XLEN +: XLEN];
                end
            end
        end

        if (flush_i) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                map_d[r] = '0;
            end
        end else if (ckpt_restore_i) begin
            map_d = ckpt_clr[ckpt_id_i];
        end else begin
            map_d = map_clr;
            if (issue_valid_i && rd_we_i && (rd_addr_i != '0)) begin
                map_d[rd_addr_i] = '{busy: 1'b1, tag: issue_tag_i};
            end
        end

        ckpt_d = ckpt_clr;
        if (ckpt_save_i && !ckpt_restore_i) begin
            ckpt_d[ckpt_id_i] = map_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                map_q[r] <= '0;
                for (int unsigned k = 0; k < NUM_CKPT; k++) begin
                    ckpt_q[k][r] <= '0;
                end
            end
            wb_valid_q <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            map_q      <= map_d;
            ckpt_q     <= ckpt_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_addr_o  = wb_addr_q;
    assign wb_data_o  = wb_data_q;

endmodule

// File: tb/tb_rename_map_table.sv
// Directed self-checking bench for rename_map_table: lookup/bypass, write-back,
// rename overwrite, multi-channel CDB, checkpoints, flush and asynchronous reset.
module tb_rename_map_table;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned NUM_CDB  = 2;
    localparam int unsigned NUM_CKPT = 4;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned RA       = 5;

    logic                      clk_i = 1'b0;
    logic                      rst_i = 1'b1;
    logic                      issue_valid_i, rd_we_i;
    logic [RA-1:0]             rd_addr_i, rs1_addr_i, rs2_addr_i;
    logic [TAG_W-1:0]          issue_tag_i;
    logic                      rs1_used_i, rs2_used_i;
    logic [TAG_W-1:0]          t1_o, t2_o;
    logic                      fwd1_valid_o, fwd2_valid_o;
    logic [XLEN-1:0]           fwd1_data_o, fwd2_data_o;
    logic [NUM_CDB-1:0]        cdb_valid_i;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag_i;
    logic [NUM_CDB*XLEN-1:0]   cdb_data_i;
    logic [NUM_CDB-1:0]        wb_valid_o;
    logic [NUM_CDB*RA-1:0]     wb_addr_o;
    logic [NUM_CDB*XLEN-1:0]   wb_data_o;
    logic                      ckpt_save_i, ckpt_restore_i, flush_i;
    logic [1:0]                ckpt_id_i;

    int n_cmp = 0;
    int n_err = 0;

    rename_map_table #(
        .NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .NUM_CKPT(NUM_CKPT), .XLEN(XLEN)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .issue_tag_i(issue_tag_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
        .t1_o(t1_o), .t2_o(t2_o), .fwd1_valid_o(fwd1_valid_o), .fwd2_valid_o(fwd2_valid_o),
        .fwd1_data_o(fwd1_data_o), .fwd2_data_o(fwd2_data_o),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
        .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .ckpt_save_i(ckpt_save_i), .ckpt_restore_i(ckpt_restore_i), .ckpt_id_i(ckpt_id_i), .flush_i(flush_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        issue_valid_i  = 1'b0; rd_we_i = 1'b0; rd_addr_i = '0; issue_tag_i = '0;
        rs1_addr_i     = '0;   rs2_addr_i = '0; rs1_used_i = 1'b0; rs2_used_i = 1'b0;
        cdb_valid_i    = '0;   cdb_tag_i = '0;  cdb_data_i = '0;
        ckpt_save_i    = 1'b0; ckpt_restore_i = 1'b0; ckpt_id_i = '0; flush_i = 1'b0;
    endtask

    task automatic issue(input logic [RA-1:0] rd, input logic [TAG_W-1:0] tag);
        issue_valid_i = 1'b1; rd_we_i = 1'b1; rd_addr_i = rd; issue_tag_i = tag;
    endtask

    task automatic cdb(input int ch, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
        cdb_valid_i[ch]               = 1'b1;
        cdb_tag_i[ch*TAG_W +: TAG_W]  = tag;
        cdb_data_i[ch*XLEN +: XLEN]   = data;
    endtask

    task automatic test_reset();
        idle();
        rs1_used_i = 1'b1; rs1_addr_i = 5'd5;
        #2;
        n_cmp++; if (t1_o !== 4'd0) begin n_err++; $display("FAIL reset_t1: got %0d want 0", t1_o); end
        n_cmp++; if (wb_valid_o !== 2'b00 || wb_addr_o !== '0 || wb_data_o !== '0) begin
            n_err++; $display("FAIL reset_wb: valid=%b addr=%h data=%h want all zero", wb_valid_o, wb_addr_o, wb_data_o);
        end
        tick(); tick();
        rst_i = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_basic();
        issue(5'd5, 4'd3); tick(); idle();
        rs1_used_i = 1'b1; rs1_addr_i = 5'd5; rs2_used_i = 1'b1; rs2_addr_i = 5'd5;
        #1;
        n_cmp++; if (t1_o !== 4'd3 || fwd1_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_t1: got t1=%0d fwd=%b want 3/0", t1_o, fwd1_valid_o); end
        n_cmp++; if (t2_o !== 4'd3) begin n_err++; $display("FAIL basic_t2: got %0d want 3", t2_o); end
        cdb(0, 4'd3, 32'hDEADBEEF);
        #1;
        n_cmp++; if (t1_o !== 4'd0 || fwd1_valid_o !== 1'b1 || fwd1_data_o !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL basic_bypass: got t1=%0d fwd=%b data=%h want 0/1/deadbeef", t1_o, fwd1_valid_o, fwd1_data_o);
        end
        tick();
        n_cmp++; if (wb_valid_o !== 2'b01 || wb_addr_o[RA-1:0] !== 5'd5 || wb_data_o[XLEN-1:0] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL basic_wb: got v=%b a=%0d d=%h want 01/5/deadbeef", wb_valid_o, wb_addr_o[RA-1:0], wb_data_o[XLEN-1:0]);
        end
        cdb_valid_i = '0;
        #1;
        n_cmp++; if (t1_o !== 4'd0 || fwd1_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_free: got t1=%0d fwd=%b want 0/0", t1_o, fwd1_valid_o); end
        idle();
    endtask

    task automatic test_rename();
        issue(5'd7, 4'd2); tick();
        issue(5'd7, 4'd4); tick(); idle();
        cdb(0, 4'd2, 32'h0000_0022); tick(); idle();
        n_cmp++; if (wb_valid_o !== 2'b00) begin n_err++; $display("FAIL rename_stale_wb: got %b want 00", wb_valid_o); end
        cdb(0, 4'd4, 32'h0000_0044); tick(); idle();
        n_cmp++; if (wb_valid_o !== 2'b01 || wb_addr_o[RA-1:0] !== 5'd7 || wb_data_o[XLEN-1:0] !== 32'h44) begin
            n_err++; $display("FAIL rename_wb: got v=%b a=%0d d=%h want 01/7/44", wb_valid_o, wb_addr_o[RA-1:0], wb_data_o[XLEN-1:0]);
        end
    endtask

    task automatic test_issue_vs_cdb();
        issue(5'd9, 4'd1); tick(); idle();
        issue(5'd9, 4'd6); cdb(1, 4'd1, 32'h1111_1111); tick(); idle();
        n_cmp++; if (wb_valid_o !== 2'b10 || wb_addr_o[2*RA-1:RA] !== 5'd9 || wb_data_o[2*XLEN-1:XLEN] !== 32'h1111_1111) begin
            n_err++; $display("FAIL collide_wb: got v=%b a=%0d d=%h want 10/9/11111111", wb_valid_o, wb_addr_o[2*RA-1:RA], wb_data_o[2*XLEN-1:XLEN]);
        end
        rs1_used_i = 1'b1; rs1_addr_i = 5'd9;
        #1;
        n_cmp++; if (t1_o !== 4'd6) begin n_err++; $display("FAIL collide_map: got %0d want 6", t1_o); end
        idle();
    endtask

    task automatic test_dual_cdb();
        issue(5'd3, 4'd1); tick();
        issue(5'd4, 4'd2); tick(); idle();
        rs1_used_i = 1'b1; rs1_addr_i = 5'd3; rs2_used_i = 1'b1; rs2_addr_i = 5'd4;
        cdb(0, 4'd1, 32'hAAAA_0001); cdb(1, 4'd2, 32'hBBBB_0002);
        #1;
        n_cmp++; if (fwd1_data_o !== 32'hAAAA_0001 || fwd2_data_o !== 32'hBBBB_0002 || fwd1_valid_o !== 1'b1 || fwd2_valid_o !== 1'b1) begin
            n_err++; $display("FAIL dual_bypass: got %b:%h %b:%h want 1:aaaa0001 1:bbbb0002", fwd1_valid_o, fwd1_data_o, fwd2_valid_o, fwd2_data_o);
        end
        tick(); idle();
        n_cmp++; if (wb_valid_o !== 2'b11 || wb_addr_o !== {5'd4, 5'd3} || wb_data_o !== {32'hBBBB_0002, 32'hAAAA_0001}) begin
            n_err++; $display("FAIL dual_wb: got v=%b a=%h d=%h want 11/%h/bbbb0002aaaa0001", wb_valid_o, wb_addr_o, wb_data_o, {5'd4, 5'd3});
        end
    endtask

    task automatic test_ckpt();
        issue(5'd2, 4'd5); tick(); idle();
        ckpt_save_i = 1'b1; ckpt_id_i = 2'd1; tick(); idle();
        issue(5'd2, 4'd7); tick(); idle();
        cdb(0, 4'd5, 32'h5555_5555); tick(); idle();
        n_cmp++; if (wb_valid_o !== 2'b00) begin n_err++; $display("FAIL ckpt_stale_wb: got %b want 00", wb_valid_o); end
        ckpt_restore_i = 1'b1; ckpt_id_i = 2'd1; tick(); idle();
        rs1_used_i = 1'b1; rs1_addr_i = 5'd2; rs2_used_i = 1'b1; rs2_addr_i = 5'd9;
        #1;
        n_cmp++; if (t1_o !== 4'd0) begin n_err++; $display("FAIL ckpt_x2: got %0d want 0", t1_o); end
        n_cmp++; if (t2_o !== 4'd6) begin n_err++; $display("FAIL ckpt_x9: got %0d want 6", t2_o); end
        idle();
    endtask

    task automatic test_flush();
        flush_i = 1'b1; issue(5'd10, 4'd8); cdb(0, 4'd6, 32'h6666_6666); tick(); idle();
        n_cmp++; if (wb_valid_o !== 2'b01 || wb_addr_o[RA-1:0] !== 5'd9 || wb_data_o[XLEN-1:0] !== 32'h6666_6666) begin
            n_err++; $display("FAIL flush_wb: got v=%b a=%0d d=%h want 01/9/66666666", wb_valid_o, wb_addr_o[RA-1:0], wb_data_o[XLEN-1:0]);
        end
        rs1_used_i = 1'b1; rs1_addr_i = 5'd10;
        #1;
        n_cmp++; if (t1_o !== 4'd0) begin n_err++; $display("FAIL flush_issue_ignored: got %0d want 0", t1_o); end
        idle();
    endtask

    task automatic test_x0_and_async_reset();
        issue(5'd0, 4'd3); tick();
        issue(5'd11, 4'd9); tick();
        issue(5'd12, 4'd10); tick(); idle();
        rs1_used_i = 1'b1; rs1_addr_i = 5'd0; rs2_used_i = 1'b0; rs2_addr_i = 5'd11;
        #1;
        n_cmp++; if (t1_o !== 4'd0 || t2_o !== 4'd0) begin n_err++; $display("FAIL x0_unused: got t1=%0d t2=%0d want 0/0", t1_o, t2_o); end
        rs2_used_i = 1'b1;
        #1;
        n_cmp++; if (t2_o !== 4'd9) begin n_err++; $display("FAIL used_t2: got %0d want 9", t2_o); end
        rs1_addr_i = 5'd12;
        cdb(0, 4'd9, 32'h9999_0009); tick();
        cdb_valid_i = '0;
        n_cmp++; if (wb_valid_o !== 2'b01 || t1_o !== 4'd10) begin
            n_err++; $display("FAIL pre_reset: got wb=%b t1=%0d want 01/10", wb_valid_o, t1_o);
        end
        #1 rst_i = 1'b1;
        #1;
        n_cmp++; if (wb_valid_o !== 2'b00 || wb_addr_o !== '0 || wb_data_o !== '0 || t1_o !== 4'd0) begin
            n_err++; $display("FAIL async_reset: got wb=%b a=%h d=%h t1=%0d want zeros", wb_valid_o, wb_addr_o, wb_data_o, t1_o);
        end
        tick();
        rst_i = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rename();
        test_issue_vs_cdb();
        test_dual_cdb();
        test_ckpt();
        test_flush();
        test_x0_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
